// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of an 8x16 data memory
// (memory writes on posedge, reads on negedge). Each granted access runs
// IDLE -> ACCESS -> RESP, giving one access per three cycles at best.
// Port 0 is the load/store stage, port 1 the debug/DMA loader.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking;
// otherwise port 0 always wins a tie.
module dmem_arbiter #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [DW-1:0] mem_d,
  output logic [AW-1:0] mem_a,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_m,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          lat_we;
  logic          lat_port;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          last_grant;
  logic          grant_any;
  logic          grant_port;

  // Pick the winning port from the requests seen this cycle.
  always_comb begin
    grant_any  = p0_req | p1_req;
    grant_port = 1'b0;
    if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
      grant_port = ~last_grant;
`else
      grant_port = 1'b0;
`endif
    end else if (p1_req) begin
      grant_port = 1'b1;
    end
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed priority still tracks the last grant but never consults it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed three-step sequence once a port is granted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state: write strobe only in ACCESS, ack only in RESP.
  always_comb begin
    mem_wr = 1'b0;
    p0_ack = 1'b0;
    p1_ack = 1'b0;
    busy   = (state != IDLE);
    case (state)
      ACCESS:  mem_wr = lat_we;
      RESP: begin
        p0_ack = ~lat_port;
        p1_ack = lat_port;
      end
      default: ;
    endcase
  end

  // Memory pins follow the latched request so they hold between accesses.
  assign mem_a = lat_addr;
  assign mem_d = lat_wdata;

  // Latch the granted request in IDLE; capture load data at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_port   <= 1'b0;
      last_grant <= 1'b1;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        lat_port   <= grant_port;
        last_grant <= grant_port;
        if (grant_port) begin
          lat_addr  <= p1_addr;
          lat_wdata <= p1_wdata;
          lat_we    <= p1_we;
        end else begin
          lat_addr  <= p0_addr;
          lat_wdata <= p0_wdata;
          lat_we    <= p0_we;
        end
      end
      if (state == ACCESS && !lat_we) begin
        if (lat_port) p1_rdata <= mem_m;
        else          p0_rdata <= mem_m;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 8x16 memory
// (posedge write, negedge read) attached to the memory pins.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack, mem_wr, busy;
  logic [15:0] p0_rdata, p1_rdata, mem_d, mem_m;
  logic [2:0]  mem_a;

  int checks = 0;
  int errors = 0;
  int wr_total = 0;
  logic [15:0] mem [8];
  logic [15:0] exp_rd0, exp_rd1;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_d(mem_d), .mem_a(mem_a), .mem_wr(mem_wr), .mem_m(mem_m), .busy(busy)
  );

  // Memory model
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    mem_m = 16'h0000;
  end
  always @(posedge clk) if (mem_wr) mem[mem_a] <= mem_d;
  always @(negedge clk) mem_m <= mem[mem_a];
  always @(negedge clk) if (mem_wr) wr_total <= wr_total + 1;

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } txn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete transaction on a single port, checking latency, data and strobe.
  task automatic run_txn(input txn_t t);
    int lat;
    bit got;
    bit other;
    int wr0;
    @(posedge clk); #1;
    wr0 = wr_total;
    if (t.port) begin
      p1_we = t.we; p1_addr = t.addr; p1_wdata = t.wdata; p1_req = 1'b1;
    end else begin
      p0_we = t.we; p0_addr = t.addr; p0_wdata = t.wdata; p0_req = 1'b1;
    end
    lat = 0; got = 1'b0; other = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if ((t.port ? p1_ack : p0_ack) === 1'b1) got = 1'b1;
      if ((t.port ? p0_ack : p1_ack) === 1'b1) other = 1'b1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", lat, 32'd2);
    chk("other_ack", {31'd0, other}, 32'd0);
    if (!t.we) begin
      if (t.port) exp_rd1 = t.exp_rd;
      else        exp_rd0 = t.exp_rd;
    end
    chk("p0_rdata", {16'd0, p0_rdata}, {16'd0, exp_rd0});
    chk("p1_rdata", {16'd0, p1_rdata}, {16'd0, exp_rd1});
    @(posedge clk); #1;
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("ack_cleared", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("mem_wr_cycles", wr_total - wr0, t.we ? 32'd1 : 32'd0);
  endtask

  txn_t vec [5];
  int   gr [4];
  int   ng;
  int   cyc;
  bit   ack1_seen;
  int   wr0;

  initial begin
    vec[0] = '{port: 1'b0, we: 1'b1, addr: 3'd3, wdata: 16'hBEEF, exp_rd: 16'h0000};
    vec[1] = '{port: 1'b0, we: 1'b0, addr: 3'd3, wdata: 16'h0000, exp_rd: 16'hBEEF};
    vec[2] = '{port: 1'b1, we: 1'b1, addr: 3'd6, wdata: 16'hA5A5, exp_rd: 16'h0000};
    vec[3] = '{port: 1'b0, we: 1'b0, addr: 3'd6, wdata: 16'h0000, exp_rd: 16'hA5A5};
    vec[4] = '{port: 1'b1, we: 1'b0, addr: 3'd5, wdata: 16'h0000, exp_rd: 16'h0000};

    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 3'd0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 3'd0; p1_wdata = 16'h0;
    exp_rd0 = 16'h0; exp_rd1 = 16'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
    chk("rst_mem_a", {29'd0, mem_a}, 32'd0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_state", {busy, mem_wr, p0_ack, p1_ack, 25'd0, mem_a}, 32'd0);
    end

    // Single-port transactions from the table
    for (int i = 0; i < 5; i++) run_txn(vec[i]);

    // Both ports requesting continuously for four transactions
    @(posedge clk); #1;
    p0_we = 1'b0; p0_addr = 3'd1; p1_we = 1'b0; p1_addr = 3'd2;
    p0_req = 1'b1; p1_req = 1'b1;
    ng = 0; cyc = 0;
    while (ng < 4 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      if (p0_ack === 1'b1 && ng < 4) begin gr[ng] = 0; ng++; end
      if (p1_ack === 1'b1 && ng < 4) begin gr[ng] = 1; ng++; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("tie_count", ng, 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      chk("tie_grant", gr[i], (i % 2 == 0) ? 32'd0 : 32'd1);
`else
      chk("tie_grant", gr[i], 32'd0);
`endif
    end
    chk("tie_p0_rdata", {16'd0, p0_rdata}, 32'd0);
    repeat (2) @(posedge clk);

    // Reset pulse in the middle of a port 1 store's ACCESS cycle
    @(posedge clk); #1;
    wr0 = wr_total;
    p1_we = 1'b1; p1_addr = 3'd7; p1_wdata = 16'h1234; p1_req = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_access", {30'd0, busy, mem_wr}, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_wr_drop", {30'd0, busy, mem_wr}, 32'd0);
    p1_req = 1'b0;
    #2 rst_n = 1'b1;
    exp_rd0 = 16'h0; exp_rd1 = 16'h0;
    ack1_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (p1_ack === 1'b1) ack1_seen = 1'b1;
    end
    chk("abort_no_ack", {31'd0, ack1_seen}, 32'd0);
    chk("abort_no_write", wr_total - wr0, 32'd0);
    run_txn('{port: 1'b1, we: 1'b0, addr: 3'd7, wdata: 16'h0, exp_rd: 16'h0000});

    // Port 0 store immediately followed by a port 1 load of the same word
    @(posedge clk); #1;
    p0_we = 1'b1; p0_addr = 3'd0; p0_wdata = 16'h00FF; p0_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_p0_ack", {31'd0, p0_ack}, 32'd1);
    p0_req = 1'b0;
    p1_we = 1'b0; p1_addr = 3'd0; p1_req = 1'b1;
    @(posedge clk); #1;
    chk("b2b_gap_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_busy_again", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_p1_ack", {31'd0, p1_ack}, 32'd1);
    chk("b2b_p1_rdata", {16'd0, p1_rdata}, 32'h00FF);
    p1_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
